// File: rtl/local_tx_port.sv
// rtl/local_tx_port.sv - NoC injection transmitter: packet request + payload to flit stream (define TX_STATS_EN for flit/stall counters)

package noc_params;
  localparam int MESH_SIZE_X       = 4;
  localparam int MESH_SIZE_Y       = 4;
  localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM            = 2;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module local_tx_port #(
  parameter int  MAX_PKT_LEN = 8,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  pkt_valid_i,
  output logic                                  pkt_ready_o,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  logic [LEN_W-1:0]                      pkt_len_i,
  input  logic [noc_params::FLIT_DATA_SIZE-1:0] payload_i,
  input  logic                                  payload_valid_i,
  output logic                                  payload_ready_o,
  input  logic [noc_params::VC_NUM-1:0]         on_off_i,
  input  logic [noc_params::VC_NUM-1:0]         vc_allocatable_i,
  output noc_params::flit_t                     data_o,
  output logic                                  valid_flit_o
`ifdef TX_STATS_EN
  ,
  output logic [31:0]                           flits_sent_o,
  output logic [31:0]                           stall_cycles_o
`endif
);

  localparam int VC_NUM  = noc_params::VC_NUM;
  localparam int VC_SIZE = noc_params::VC_SIZE;

  typedef enum logic [1:0] {IDLE, VC_SEL, HEAD, BODY} state_t;

  state_t                                  state_q, state_d;
  logic [noc_params::DEST_ADDR_SIZE_X-1:0] x_q;
  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] y_q;
  logic [LEN_W-1:0]                        len_q;
  logic [LEN_W-1:0]                        rem_q, rem_d;
  logic [VC_SIZE-1:0]                      cur_vc_q, cur_vc_d;
  logic [VC_SIZE-1:0]                      rr_ptr_q, rr_ptr_d;
  logic                                    emit;
  noc_params::flit_t                       flit_d;
  logic                                    cur_on;
  logic                                    found;
  int                                      idx;

  // Flow control for the owned VC; only meaningful in HEAD/BODY.
  assign cur_on = on_off_i[cur_vc_q];

  // Next-state, VC arbitration and flit assembly for the current cycle.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    cur_vc_d        = cur_vc_q;
    rr_ptr_d        = rr_ptr_q;
    emit            = 1'b0;
    flit_d          = '0;
    pkt_ready_o     = 1'b0;
    payload_ready_o = 1'b0;
    found           = 1'b0;
    idx             = 0;
    case (state_q)
      IDLE: begin
        pkt_ready_o = 1'b1;
        if (pkt_valid_i) state_d = VC_SEL;
      end
      VC_SEL: begin
        // First allocatable-and-on VC at or after the round-robin pointer.
        for (int i = 0; i < VC_NUM; i++) begin
          idx = (int'(rr_ptr_q) + i) % VC_NUM;
          if (!found && vc_allocatable_i[idx] && on_off_i[idx]) begin
            found    = 1'b1;
            cur_vc_d = VC_SIZE'(idx);
            rr_ptr_d = VC_SIZE'((idx + 1) % VC_NUM);
          end
        end
        if (found) state_d = HEAD;
      end
      HEAD: begin
        if (cur_on) begin
          emit                         = 1'b1;
          flit_d.vc_id                 = cur_vc_q;
          flit_d.data.head_data.x_dest = x_q;
          flit_d.data.head_data.y_dest = y_q;
          if (len_q == LEN_W'(1)) begin
            flit_d.flit_label = noc_params::HEADTAIL;
            state_d           = IDLE;
          end else begin
            flit_d.flit_label = noc_params::HEAD;
            rem_d             = len_q - LEN_W'(1);
            state_d           = BODY;
          end
        end
      end
      BODY: begin
        if (payload_valid_i && cur_on) begin
          emit             = 1'b1;
          payload_ready_o  = 1'b1;
          flit_d.vc_id     = cur_vc_q;
          flit_d.data.bt_pl = payload_i;
          if (rem_q == LEN_W'(1)) begin
            flit_d.flit_label = noc_params::TAIL;
            state_d           = IDLE;
          end else begin
            flit_d.flit_label = noc_params::BODY;
          end
          rem_d = rem_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request fields and the registered flit output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      cur_vc_q     <= '0;
      rr_ptr_q     <= '0;
      data_o       <= '0;
      valid_flit_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cur_vc_q <= cur_vc_d;
      rr_ptr_q <= rr_ptr_d;
      if (state_q == IDLE && pkt_valid_i) begin
        x_q   <= x_dest_i;
        y_q   <= y_dest_i;
        // A zero length still produces a single HEADTAIL flit.
        len_q <= (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
      end
      data_o       <= flit_d;
      valid_flit_o <= emit;
    end
  end

`ifdef TX_STATS_EN
  // Free-running wrap-around counters of issued flits and flow-control stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flits_sent_o   <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (valid_flit_o) flits_sent_o <= flits_sent_o + 32'd1;
      if ((state_q == HEAD || state_q == BODY) && !cur_on)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_local_tx_port.sv
// tb/tb_local_tx_port.sv - directed self-checking bench for local_tx_port
module tb_local_tx_port;
  import noc_params::*;

  localparam int LEN_W = $clog2(8) + 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        pkt_valid_i;
  logic                        pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i;
  logic [LEN_W-1:0]            pkt_len_i;
  logic [FLIT_DATA_SIZE-1:0]   payload_i;
  logic                        payload_valid_i;
  logic                        payload_ready_o;
  logic [VC_NUM-1:0]           on_off_i;
  logic [VC_NUM-1:0]           vc_allocatable_i;
  flit_t                       data_o;
  logic                        valid_flit_o;
`ifdef TX_STATS_EN
  logic [31:0]                 flits_sent_o;
  logic [31:0]                 stall_cycles_o;
`endif

  int errors = 0;
  int checks = 0;

  local_tx_port #(.MAX_PKT_LEN(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_o      (pkt_ready_o),
    .x_dest_i         (x_dest_i),
    .y_dest_i         (y_dest_i),
    .pkt_len_i        (pkt_len_i),
    .payload_i        (payload_i),
    .payload_valid_i  (payload_valid_i),
    .payload_ready_o  (payload_ready_o),
    .on_off_i         (on_off_i),
    .vc_allocatable_i (vc_allocatable_i),
    .data_o           (data_o),
    .valid_flit_o     (valid_flit_o)
`ifdef TX_STATS_EN
    ,
    .flits_sent_o     (flits_sent_o),
    .stall_cycles_o   (stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mk_head(input flit_label_t l, input int vc, input int x, input int y);
    flit_t f;
    f = '0;
    f.flit_label = l;
    f.vc_id = VC_SIZE'(vc);
    f.data.head_data.x_dest = DEST_ADDR_SIZE_X'(x);
    f.data.head_data.y_dest = DEST_ADDR_SIZE_Y'(y);
    return f;
  endfunction

  function automatic flit_t mk_bt(input flit_label_t l, input int vc, input int pl);
    flit_t f;
    f = '0;
    f.flit_label = l;
    f.vc_id = VC_SIZE'(vc);
    f.data.bt_pl = FLIT_DATA_SIZE'(pl);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int x, input int y, input int len);
    pkt_valid_i = 1'b1;
    x_dest_i    = DEST_ADDR_SIZE_X'(x);
    y_dest_i    = DEST_ADDR_SIZE_Y'(y);
    pkt_len_i   = LEN_W'(len);
    #1;
    chk("accept_pkt_ready", 64'(pkt_ready_o), 64'd1);
    step();
    pkt_valid_i = 1'b0;
  endtask

  task automatic send1(input string tag, input int x, input int y, input int vc);
    accept(x, y, 1);
    step();
    step();
    chk({tag, "_valid"}, 64'(valid_flit_o), 64'd1);
    chk({tag, "_flit"}, 64'(data_o), 64'(mk_head(HEADTAIL, vc, x, y)));
    chk({tag, "_pkt_ready"}, 64'(pkt_ready_o), 64'd1);
    step();
    chk({tag, "_idle"}, 64'(valid_flit_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    pkt_valid_i = 1'b0;
    x_dest_i = '0;
    y_dest_i = '0;
    pkt_len_i = '0;
    payload_i = '0;
    payload_valid_i = 1'b0;
    on_off_i = 2'b11;
    vc_allocatable_i = 2'b11;
    #2;
    chk("rst_pkt_ready", 64'(pkt_ready_o), 64'd1);
    chk("rst_payload_ready", 64'(payload_ready_o), 64'd0);
    chk("rst_valid", 64'(valid_flit_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    #10 rst = 1'b0;
    step();

    // Single-flit packet: HEADTAIL on vc 0, two cycles after acceptance
    accept(1, 2, 1);
    chk("t1_vcsel_pkt_ready", 64'(pkt_ready_o), 64'd0);
    chk("t1_vcsel_valid", 64'(valid_flit_o), 64'd0);
    step();
    chk("t1_head_state_valid", 64'(valid_flit_o), 64'd0);
    step();
    chk("t1_valid", 64'(valid_flit_o), 64'd1);
    chk("t1_flit", 64'(data_o), 64'(mk_head(HEADTAIL, 0, 1, 2)));
    chk("t1_pkt_ready", 64'(pkt_ready_o), 64'd1);
    step();
    chk("t1_after", 64'(valid_flit_o), 64'd0);

    // 4-flit packet on vc 1; early payload is not consumed before BODY
    accept(3, 1, 4);
    payload_valid_i = 1'b1;
    payload_i = 16'hA;
    #1;
    chk("t2_vcsel_payload_ready", 64'(payload_ready_o), 64'd0);
    step();
    chk("t2_head_payload_ready", 64'(payload_ready_o), 64'd0);
    step();
    chk("t2_head_valid", 64'(valid_flit_o), 64'd1);
    chk("t2_head", 64'(data_o), 64'(mk_head(HEAD, 1, 3, 1)));
    chk("t2_body_payload_ready", 64'(payload_ready_o), 64'd1);
    step();
    chk("t2_body_a", 64'(data_o), 64'(mk_bt(BODY, 1, 'hA)));
    payload_i = 16'hB;
    step();
    chk("t2_body_b", 64'(data_o), 64'(mk_bt(BODY, 1, 'hB)));
    payload_i = 16'hC;
    step();
    chk("t2_tail_valid", 64'(valid_flit_o), 64'd1);
    chk("t2_tail_c", 64'(data_o), 64'(mk_bt(TAIL, 1, 'hC)));
    chk("t2_idle_payload_ready", 64'(payload_ready_o), 64'd0);
    chk("t2_idle_pkt_ready", 64'(pkt_ready_o), 64'd1);
    payload_valid_i = 1'b0;
    step();
    chk("t2_after", 64'(valid_flit_o), 64'd0);

    // Backpressure on vc 0 for 3 cycles after the first body flit
    accept(2, 3, 3);
    payload_valid_i = 1'b1;
    payload_i = 16'h1;
    step();
    step();
    chk("t3_head", 64'(data_o), 64'(mk_head(HEAD, 0, 2, 3)));
    step();
    chk("t3_body_1", 64'(data_o), 64'(mk_bt(BODY, 0, 'h1)));
    payload_i = 16'h2;
    on_off_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_payload_ready", 64'(payload_ready_o), 64'd0);
      step();
      chk("t3_stall_valid", 64'(valid_flit_o), 64'd0);
    end
    on_off_i = 2'b11;
    #1;
    chk("t3_resume_payload_ready", 64'(payload_ready_o), 64'd1);
    step();
    chk("t3_tail_valid", 64'(valid_flit_o), 64'd1);
    chk("t3_tail_2", 64'(data_o), 64'(mk_bt(TAIL, 0, 'h2)));
    payload_valid_i = 1'b0;
    step();
    chk("t3_after", 64'(valid_flit_o), 64'd0);

    // Pointer at 1 but only vc 0 allocatable
    vc_allocatable_i = 2'b01;
    send1("t4_alloc_mask", 0, 1, 0);
    vc_allocatable_i = 2'b11;

    // Payload starvation for 5 cycles mid-packet on vc 1
    accept(1, 1, 3);
    step();
    step();
    chk("t5_head", 64'(data_o), 64'(mk_head(HEAD, 1, 1, 1)));
    payload_valid_i = 1'b1;
    payload_i = 16'h5;
    step();
    chk("t5_body_5", 64'(data_o), 64'(mk_bt(BODY, 1, 'h5)));
    payload_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_starve_payload_ready", 64'(payload_ready_o), 64'd0);
      step();
      chk("t5_starve_valid", 64'(valid_flit_o), 64'd0);
    end
    payload_valid_i = 1'b1;
    payload_i = 16'h6;
    step();
    chk("t5_tail_6", 64'(data_o), 64'(mk_bt(TAIL, 1, 'h6)));
    payload_valid_i = 1'b0;
    step();

    // Asynchronous reset in the middle of BODY
    accept(2, 2, 4);
    step();
    step();
    chk("t6_head", 64'(data_o), 64'(mk_head(HEAD, 0, 2, 2)));
    payload_valid_i = 1'b1;
    payload_i = 16'h7;
    step();
    chk("t6_body_valid", 64'(valid_flit_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(valid_flit_o), 64'd0);
    chk("t6_rst_data", 64'(data_o), 64'd0);
    chk("t6_rst_pkt_ready", 64'(pkt_ready_o), 64'd1);
    step();
    rst = 1'b0;
    #1;
    chk("t6_rel_pkt_ready", 64'(pkt_ready_o), 64'd1);
    chk("t6_rel_payload_ready", 64'(payload_ready_o), 64'd0);
`ifdef TX_STATS_EN
    chk("t6_flits_sent", 64'(flits_sent_o), 64'd0);
    chk("t6_stall_cycles", 64'(stall_cycles_o), 64'd0);
`endif
    payload_valid_i = 1'b0;
    step();

    // Round-robin from a freshly reset pointer: 0, 1, 0
    send1("t7_rr0", 1, 0, 0);
    send1("t7_rr1", 2, 1, 1);
    send1("t7_rr2", 3, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/local_tx_port.md
Name: local_tx_port

Overview:
- Injection-side transmitter in the node network interface. It drives a router's local input port: it converts packet requests plus payload words into a flit_t stream (HEAD/BODY/TAIL or HEADTAIL).
- It picks one downstream VC per packet, stamps vc_id on every flit and obeys the per-VC on/off flow control returned by the input port.
- It sends one packet at a time, and all flits of a packet go on the same VC.

Parameters:
- MAX_PKT_LEN, 8, maximum flits per packet (head included); pkt_len_i range is 1..MAX_PKT_LEN.
- VC_NUM, SIZE and address constants come from noc_params.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pkt_valid_i  in  1  packet request valid
- pkt_ready_o  out  1  request accepted when pkt_valid_i && pkt_ready_o
- x_dest_i  in  DEST_ADDR_SIZE_X  destination x, sampled at acceptance
- y_dest_i  in  DEST_ADDR_SIZE_Y  destination y, sampled at acceptance
- pkt_len_i  in  $clog2(MAX_PKT_LEN)+1  flit count, sampled at acceptance
- payload_i  in  FLIT_DATA_SIZE  body/tail payload word
- payload_valid_i  in  1  payload word valid
- payload_ready_o  out  1  payload word consumed this cycle
- on_off_i  in  VC_NUM  downstream per-VC on (1) / off (0)
- vc_allocatable_i  in  VC_NUM  downstream VC idle, may take a new head
- data_o  out  flit_t  flit to router input port
- valid_flit_o  out  1  data_o valid this cycle

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - pkt_ready_o=1, payload_ready_o=0, valid_flit_o=0, data_o all zero.
  - Round-robin pointer = 0; captured dest, len and vc are cleared.
- FSM states: IDLE, VC_SEL, HEAD, BODY.
- IDLE:
  - pkt_ready_o=1.
  - On acceptance, register dest and len; a captured len of 0 is treated as 1.
  - Next state is VC_SEL.
- VC_SEL:
  - Round-robin search starting at the pointer for a VC with vc_allocatable_i && on_off_i.
  - If found, latch it as cur_vc, set pointer = cur_vc+1 mod VC_NUM, go to HEAD.
  - If none is found, stay in VC_SEL. This is one cycle minimum; there is no combinational IDLE→send.
- HEAD:
  - If on_off_i[cur_vc]=1: valid_flit_o=1 for one cycle with vc_id=cur_vc, head_data.x_dest/y_dest from the captured dest, and the remaining head bits zero.
  - flit_label=HEADTAIL if len==1 (then go to IDLE); otherwise HEAD (then go to BODY, remaining=len-1).
  - If on_off_i[cur_vc]=0: hold, valid_flit_o=0.
- BODY:
  - A flit is emitted only when payload_valid_i && on_off_i[cur_vc]. The same cycle asserts payload_ready_o=1 and valid_flit_o=1, with data_o carrying payload_i and vc_id=cur_vc.
  - flit_label=TAIL when remaining==1, which returns the FSM to IDLE; otherwise BODY, and remaining decrements.
  - Otherwise payload_ready_o=0 and valid_flit_o=0 (stall).
- Registered outputs:
  - data_o and valid_flit_o are registered: the flit appears the cycle after the emit decision, giving 1-cycle latency.
  - payload_ready_o is combinational from state, payload_valid_i and on_off_i.
- Flow control:
  - on_off_i is sampled each cycle.
  - The downstream buffer already reserves slack for in-flight flits, so one flit may issue in the cycle off is first seen. Decisions use the current-cycle on_off_i only.
- Downstream VC status:
  - vc_allocatable_i is consulted only in VC_SEL.
  - A VC stays owned until the tail is sent, regardless of later vc_allocatable_i changes.
- Back-to-back packets:
  - pkt_ready_o returns high in the cycle after the tail or headtail is emitted.
  - Consecutive packets rotate VCs via the pointer.
- Extra payload words are never consumed outside BODY; payload_valid_i outside BODY is ignored.
- Reset mid-packet: everything aborts immediately and valid_flit_o drops asynchronously. A truncated packet downstream is the system's responsibility.

Optional Feature:
- TX_STATS_EN:
  - When defined, adds outputs flits_sent_o (32 bits, increments per valid_flit_o) and stall_cycles_o (32 bits, increments each cycle in HEAD/BODY when on_off_i[cur_vc]=0).
  - Both are cleared by rst and wrap at 2^32.
  - Without the macro, neither the ports nor the counters exist.

Test Plan:
- Single-flit packet: len=1, dest (1,2), all VCs allocatable/on → one HEADTAIL on vc 0, 2 cycles after acceptance; pkt_ready_o high again the next cycle.
- 4-flit packet, payload words 0xA,0xB,0xC streamed → HEAD, BODY 0xA, BODY 0xB, TAIL 0xC, all same vc_id, consecutive cycles.
- Backpressure: drop on_off_i[cur_vc] after the first body flit for 3 cycles → no flits and payload_ready_o=0 for 3 cycles, then resume with no loss or duplication.
- VC selection: vc_allocatable_i=0b01 with VC_NUM=2 and pointer at 1 → vc 0 chosen; three sequential packets with all VCs free → vc_ids 0,1,0.
- Payload starvation: payload_valid_i low for 5 cycles mid-packet → valid_flit_o low, FSM stays in BODY, label sequence intact.
- Async reset asserted mid-BODY → valid_flit_o=0 immediately and pkt_ready_o=1 after release; with TX_STATS_EN, both counters read 0.
